// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, InvSubBytes FSM encoding and GF(2^8) multiply
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: AES inverse S-box, inverse affine map followed by GF(2^8) inversion
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;
  logic [7:0] p;
  // undo the affine map, then raise to the 254th power (0 maps to 0)
  always_comb begin
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    p = b;
    y = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      y = gmul(y, p);
    end
  end
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: InvSubBytes over a 128-bit state, NUM_SBOX bytes per cycle
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   busy
);
  localparam int GROUPS = AES_BYTES / NUM_SBOX;
  localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int W = 8 * NUM_SBOX;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] src_q, src_d, res_q, res_d;
  logic [W-1:0] grp_src, grp_res;
  assign grp_src = src_q[AES_BLOCK_W-1-W*int'(cnt_q) -: W];
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    inv_sbox u_sbox (
      .a(grp_src[W-1-8*i -: 8]),
      .y(grp_res[W-1-8*i -: 8])
    );
  end
  // next-state: capture in IDLE, one byte group per BUSY cycle, hand off in DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    res_d = res_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          src_d = in_state;
          cnt_d = '0;
          state_d = BUSY;
        end
        BUSY: begin
          res_d[AES_BLOCK_W-1-W*int'(cnt_q) -: W] = grp_res;
          if (cnt_q == CW'(GROUPS - 1)) state_d = DONE;
          else cnt_d = cnt_q + CW'(1);
        end
        DONE: if (out_ready) begin
          state_d = IDLE;
          cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state, counter and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      src_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      res_q <= res_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_state = res_q;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed and random checks against a table built from the forward S-box
module tb_inv_sub_bytes_seq;
  localparam int NS = 4;
  localparam int G = 16 / NS;
  logic clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;
  int total = 0;
  int bad = 0;
  logic [7:0] tbl[256];
  logic [127:0] q[$];

  inv_sub_bytes_seq #(.NUM_SBOX(NS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_table();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = tbl[v[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input string tag, input logic [127:0] v);
    int n = 0;
    in_state = v;
    in_valid = 1;
    step();
    in_valid = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(G));
    chk({tag, "_data"}, out_state, ref_block(v));
    out_ready = 1;
    step();
    out_ready = 0;
    chk({tag, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
  endtask

  initial begin
    int sent, got, cyc;
    logic [127:0] held;
    build_table();
    rst_n = 0; clr = 0; in_valid = 0; out_ready = 0; in_state = '0;
    #12;
    chk("rst_ctl", {busy, in_ready, out_valid}, 3'b010);
    chk("rst_data", out_state, '0);
    rst_n = 1;
    step();
    run_block("zero", 128'h0);
    chk("zero_const", ref_block(128'h0), {16{8'h52}});
    run_block("vec2", 128'h000102030405060708090a0b0c0d0e0f);
    chk("vec2_const", ref_block(128'h000102030405060708090a0b0c0d0e0f),
        128'h52096ad53036a538bf40a39e81f3d7fb);
    run_block("all63", {16{8'h63}});
    chk("all63_const", ref_block({16{8'h63}}), 128'h0);
    run_block("allff", {128{1'b1}});
    chk("allff_const", ref_block({128{1'b1}}), {16{8'h7d}});
    // stall in DONE with an ignored in_valid pulse
    in_state = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    in_valid = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < G; i++) step();
    held = ref_block(128'h0123456789abcdef0f1e2d3c4b5a6978);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_state = {4{$urandom}};
      chk("hold_data", out_state, held);
      chk("hold_ctl", {out_valid, in_ready}, 2'b10);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    step();
    chk("hold_nocap", {busy, in_ready}, 2'b01);
    // abort mid-block
    in_state = 128'h000102030405060708090a0b0c0d0e0f;
    in_valid = 1;
    step();
    in_valid = 0;
    if (G > 2) step();
    clr = 1;
    step();
    clr = 0;
    chk("clr_idle", {busy, in_ready, out_valid}, 3'b010);
    for (int i = 0; i < G + 2; i++) begin
      step();
      chk("clr_noval", out_valid, 0);
    end
    run_block("clr_after", 128'h000102030405060708090a0b0c0d0e0f);
    // asynchronous reset mid-block
    in_state = {16{8'hab}};
    in_valid = 1;
    step();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("arst_ctl", {busy, in_ready, out_valid}, 3'b010);
    chk("arst_data", out_state, '0);
    rst_n = 1;
    step();
    clr = 1;
    in_valid = 1;
    step();
    chk("clr_wins", busy, 0);
    clr = 0;
    in_valid = 0;
    for (int i = 0; i < G + 2; i++) begin
      step();
      chk("arst_noval", out_valid, 0);
    end
    // random blocks with random backpressure
    sent = 0; got = 0; cyc = 0;
    while (got < 200 && cyc < 20000) begin
      cyc++;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        chk("rnd_expected", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) chk("rnd_data", out_state, q[0]);
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_block(in_state));
        sent++;
      end
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      step();
    end
    in_valid = 0;
    out_ready = 0;
    chk("rnd_count", 128'(got), 128'(200));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
